// File: rtl/frenado_rampa_parcial.sv
// frenado_rampa_parcial: controlled stop sequencer.
// Steps the motor drive level down 100 -> 50 -> 30 -> off on a stop request.
// It holds each step for a number of slow ticks.
// While idle it passes the prioritised start level straight through, one cycle registered.
// Optional build macro FRENADO_REANUDAR_EN: releasing Parar mid-ramp aborts
// the ramp back to IDLE instead of completing it.
module frenado_rampa_parcial #(
    parameter int CNT_W    = 4,
    parameter int DWELL_50 = 3,
    parameter int DWELL_30 = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic in_30,
    input  logic in_50,
    input  logic in_100,
    input  logic Parar,
    input  logic Emergencia,
    output logic out_30,
    output logic out_50,
    output logic out_100,
    output logic busy,
    output logic done
);

    // A dwell of 0 behaves as a dwell of 1; the counter runs 0 .. dwell-1.
    localparam int DW50_EFF = (DWELL_50 == 0) ? 1 : DWELL_50;
    localparam int DW30_EFF = (DWELL_30 == 0) ? 1 : DWELL_30;
    localparam logic [CNT_W-1:0] DW50_LAST = CNT_W'(DW50_EFF - 1);
    localparam logic [CNT_W-1:0] DW30_LAST = CNT_W'(DW30_EFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R100,
        ST_R50,
        ST_R30,
        ST_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_lvl;        // {100, 50, 30}, one-hot or zero
    logic [2:0]         r_out;
    logic [2:0]         w_out_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    // Prioritise the start FSM level: 100 beats 50 beats 30.
    always_comb begin
        w_lvl = 3'b000;
        if (in_100) begin
            w_lvl = 3'b100;
        end else if (in_50) begin
            w_lvl = 3'b010;
        end else if (in_30) begin
            w_lvl = 3'b001;
        end
    end

    // Next state and dwell counter; emergency overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (Emergencia) begin
            w_state_nxt = ST_STOP;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Parar) begin
                        w_cnt_nxt = '0;
                        if (w_lvl[2]) begin
                            w_state_nxt = ST_R100;
                        end else if (w_lvl[1]) begin
                            w_state_nxt = ST_R50;
                        end else if (w_lvl[0]) begin
                            w_state_nxt = ST_R30;
                        end else begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
                ST_R100: begin
                    if (tick) begin
                        w_state_nxt = ST_R50;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_R50: begin
                    if (tick) begin
                        if (r_cnt == DW50_LAST) begin
                            w_state_nxt = ST_R30;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_R30: begin
                    if (tick) begin
                        if (r_cnt == DW30_LAST) begin
                            w_state_nxt = ST_STOP;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (!Parar) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
`ifdef FRENADO_REANUDAR_EN
            // Releasing the stop request mid-ramp resumes normal running.
            if (!Parar && ((r_state == ST_R100) || (r_state == ST_R50) || (r_state == ST_R30))) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
`endif
        end
    end

    // Output values decoded from the state being entered, so they appear with it.
    always_comb begin
        w_out_nxt  = 3'b000;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_out_nxt = w_lvl;
            ST_R100: begin
                w_out_nxt  = 3'b100;
                w_busy_nxt = 1'b1;
            end
            ST_R50: begin
                w_out_nxt  = 3'b010;
                w_busy_nxt = 1'b1;
            end
            ST_R30: begin
                w_out_nxt  = 3'b001;
                w_busy_nxt = 1'b1;
            end
            ST_STOP: w_done_nxt = 1'b1;
            default: w_out_nxt = 3'b000;
        endcase
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out_100 = r_out[2];
    assign out_50  = r_out[1];
    assign out_30  = r_out[0];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
